// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute-stage sequencer
// Function codes the sequencer knows about, FSM state encoding, and
// bit positions of {Z,N,C} inside the condition-code register.
package exec_pkg;
  localparam logic [3:0] FC_NOP = 4'b0000;
  localparam logic [3:0] FC_NOT = 4'b0001;
  localparam logic [3:0] FC_ADD = 4'b0010;
  localparam int CCR_Z = 2;
  localparam int CCR_N = 1;
  localparam int CCR_C = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/ccr_reg.sv
// ccr_reg: 3-bit condition-code register with per-bit masked update
// Ports: clk/rst_n (async active-low reset to 000); en gates the update;
// mask selects which bits load from flags; q is the held {Z,N,C} value.
module ccr_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] mask,
  input  logic [2:0] flags,
  output logic [2:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= (q & ~mask) | (flags & mask);
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: execute-stage controller sequencing a registered ALU
// Ports: in_* is the ID/EX valid/ready op input; alu_* drives and samples the
// registered ALU; out_* is the EX/MEM valid/ready result output; ccr holds
// {Z,N,C}; busy is high whenever the FSM is not idle; flush kills the
// in-flight op; rst_n is an asynchronous active-low reset.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int W     = 16,
  parameter int FC_W  = 4,
  parameter int DST_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FC_W-1:0]  in_fc,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [DST_W-1:0] in_dst,
  input  logic [2:0]       in_fmask,
  output logic             alu_en,
  output logic [FC_W-1:0]  alu_fc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [DST_W-1:0] out_dst,
  output logic [2:0]       ccr,
  output logic             busy
);
  state_t           state, state_d;
  logic [FC_W-1:0]  fc_q;
  logic [W-1:0]     a_q, b_q;
  logic [DST_W-1:0] dst_q;
  logic [2:0]       fmask_q, flags;
  logic             start, capture;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // Flush wins over everything; a non-NOP accept (from IDLE or on the HOLD
  // transfer cycle) always enters ISSUE.
  always_comb
    state_d = flush ? IDLE :
              start ? ISSUE :
              state == ISSUE ? CAPTURE :
              state == CAPTURE ? HOLD :
              (state == HOLD && !out_ready) ? HOLD : IDLE;
  // in_ready is gated by rst_n so it stays low while reset is held and rises
  // only once reset is released.
  always_comb begin
    in_ready  = rst_n && !flush && (state == IDLE || (state == HOLD && out_ready));
    out_valid = !flush && state == HOLD;
    alu_en    = state == ISSUE;
    busy      = state != IDLE;
    start     = in_valid && in_ready && in_fc != FC_W'(FC_NOP);
    capture   = state == CAPTURE && !flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dst_q      <= '0;
      fmask_q    <= '0;
      out_result <= '0;
      out_dst    <= '0;
    end else begin
      if (start) begin
        fc_q    <= in_fc;
        a_q     <= in_a;
        b_q     <= in_b;
        dst_q   <= in_dst;
        fmask_q <= in_fmask;
      end
      if (capture) begin
        out_result <= alu_out;
        out_dst    <= dst_q;
      end
    end
  always_comb begin
    alu_fc       = fc_q;
    alu_a        = a_q;
    alu_b        = b_q;
    flags        = '0;
    flags[CCR_Z] = alu_z;
    flags[CCR_N] = alu_n;
    flags[CCR_C] = alu_c;
  end
  ccr_reg u_ccr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (capture),
    .mask (fmask_q),
    .flags(flags),
    .q    (ccr)
  );
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed table-driven bench for exec_sequencer
module tb_exec_sequencer;
  import exec_pkg::*;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [3:0]  in_fc = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic [2:0]  in_dst = 0, in_fmask = 0;
  logic        in_ready, alu_en, out_valid, busy;
  logic [3:0]  alu_fc;
  logic [15:0] alu_a, alu_b, out_result;
  logic [2:0]  out_dst, ccr;
  logic [15:0] alu_out = 0;
  logic        alu_z = 0, alu_n = 0, alu_c = 0;
  logic [16:0] alu_next;
  logic [2:0]  ccr_exp;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0]  fc;
    logic [15:0] a, b;
    logic [2:0]  dst, m;
    logic [15:0] res;
    logic [2:0]  ccr;
  } vec_t;
  vec_t tv[7];
  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fc(in_fc), .in_a(in_a), .in_b(in_b), .in_dst(in_dst), .in_fmask(in_fmask),
    .alu_en(alu_en), .alu_fc(alu_fc), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_dst(out_dst), .ccr(ccr),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // Registered ALU: NOT, ADD with carry out, anything else returns a^b.
  always_comb
    alu_next = alu_fc == FC_NOT ? {1'b0, ~alu_b} :
               alu_fc == FC_ADD ? {1'b0, alu_a} + {1'b0, alu_b} : {1'b0, alu_a ^ alu_b};
  always @(posedge clk)
    if (alu_en) begin
      alu_out <= alu_next[15:0];
      alu_c   <= alu_next[16];
      alu_z   <= alu_next[15:0] == 16'h0;
      alu_n   <= alu_next[15];
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  // Present one op, let it be accepted at the next rising edge, scramble the
  // input bus, and return at the following falling edge.
  task automatic send(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] dst, input logic [2:0] m);
    in_valid = 1; in_fc = fc; in_a = a; in_b = b; in_dst = dst; in_fmask = m;
    @(posedge clk);
    #1 in_valid = 0; in_a = ~a; in_b = ~b; in_fc = 4'hF;
    @(negedge clk);
  endtask
  initial begin
    tv[0] = '{FC_ADD, 16'hFFFF, 16'h0001, 3'd1, 3'b111, 16'h0000, 3'b101};
    tv[1] = '{FC_NOT, 16'h0000, 16'h00FF, 3'd2, 3'b110, 16'hFF00, 3'b011};
    tv[2] = '{FC_ADD, 16'h0003, 16'h0004, 3'd3, 3'b111, 16'h0007, 3'b000};
    tv[3] = '{FC_ADD, 16'h7FFF, 16'h0001, 3'd4, 3'b010, 16'h8000, 3'b010};
    tv[4] = '{FC_NOT, 16'h1111, 16'hFFFF, 3'd5, 3'b100, 16'h0000, 3'b110};
    tv[5] = '{FC_ADD, 16'h1234, 16'h0000, 3'd6, 3'b000, 16'h1234, 3'b110};
    tv[6] = '{4'h5,   16'h00F0, 16'h0F0F, 3'd7, 3'b111, 16'h0FFF, 3'b000};
    #1;
    chk("rst_outputs", {in_ready, out_valid, alu_en, busy, ccr}, 0);
    chk("rst_result", {out_result, out_dst}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rst_release_ready", in_ready, 1);
    @(negedge clk);
    ccr_exp = 3'b000;
    // Back-to-back ops with out_ready high: each next op is accepted in HOLD.
    for (int i = 0; i < 7; i++) begin
      send(tv[i].fc, tv[i].a, tv[i].b, tv[i].dst, tv[i].m);
      chk($sformatf("v%0d_issue_en", i), {alu_en, out_valid, busy}, 3'b101);
      chk($sformatf("v%0d_issue_ops", i), {alu_fc, alu_a, alu_b}, {tv[i].fc, tv[i].a, tv[i].b});
      @(negedge clk);
      chk($sformatf("v%0d_capture", i), {alu_en, out_valid, ccr}, {2'b00, ccr_exp});
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", i), {out_valid, in_ready}, 2'b11);
      chk($sformatf("v%0d_result", i), {out_result, out_dst}, {tv[i].res, tv[i].dst});
      chk($sformatf("v%0d_ccr", i), ccr, tv[i].ccr);
      ccr_exp = tv[i].ccr;
    end
    @(negedge clk);
    chk("idle_after_transfer", {busy, out_valid, in_ready}, 3'b001);
    // Backpressure: result held stable, no accept until out_ready returns.
    out_ready = 0;
    send(FC_ADD, 16'h0003, 16'h0004, 3'd3, 3'b111);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_result}, {2'b10, 16'h0007});
      @(negedge clk);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    send(FC_ADD, 16'h0001, 16'h0001, 3'd2, 3'b000);
    chk("bp_next_issue", {alu_en, out_valid, alu_a}, {2'b10, 16'h0001});
    repeat (2) @(negedge clk);
    chk("bp_next_result", {out_valid, out_result, out_dst, ccr}, {1'b1, 16'h0002, 3'd2, 3'b000});
    @(negedge clk);
    // NOP: accepted with no ALU cycle, no result, CCR untouched.
    send(FC_NOP, 16'hFFFF, 16'h0001, 3'd1, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("nop%0d", i), {alu_en, out_valid, busy, in_ready, ccr}, 7'b0001000);
      @(negedge clk);
    end
    // Flush in CAPTURE: result dropped and carry not recorded.
    send(FC_ADD, 16'h8000, 16'h8000, 3'd4, 3'b111);
    @(negedge clk);
    flush = 1;
    #1 chk("flush_cycle", {in_ready, out_valid}, 2'b00);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush_after", {out_valid, busy, in_ready, ccr}, 6'b001000);
    @(negedge clk);
    chk("flush_no_valid", {out_valid, busy}, 2'b00);
    // Asynchronous reset while in HOLD.
    out_ready = 0;
    send(FC_ADD, 16'hFFFF, 16'h0001, 3'd5, 3'b111);
    repeat (2) @(negedge clk);
    chk("pre_reset_hold", {out_valid, ccr, out_dst}, {1'b1, 3'b101, 3'd5});
    #2 rst_n = 0;
    #1 chk("async_rst_ctl", {out_valid, alu_en, busy, in_ready, ccr}, 0);
    chk("async_rst_data", {out_result, out_dst}, 0);
    @(negedge clk);
    chk("rst_held_ready", in_ready, 0);
    rst_n = 1;
    out_ready = 1;
    #1 chk("rst_release2", {in_ready, busy}, 2'b10);
    @(negedge clk);
    send(FC_ADD, 16'h0002, 16'h0003, 3'd6, 3'b111);
    repeat (2) @(negedge clk);
    chk("post_reset_op", {out_valid, out_result, out_dst, ccr}, {1'b1, 16'h0005, 3'd6, 3'b000});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Execute-stage controller that sequences the registered 16-bit ALU for the five-stage pipeline. It accepts decoded operations from the ID/EX boundary over a valid/ready handshake and drives ALU enable, function code and operands. It captures the ALU result and flags one cycle after the ALU's clock edge, maintains the condition-code register (CCR), and presents results to EX/MEM with backpressure and flush support.

## Interface
- `W`, 16, datapath width
- `FC_W`, 4, ALU function-code width
- `DST_W`, 3, destination register index width
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `flush`  in  1  synchronous pipeline flush; kills the in-flight op
- `in_valid`  in  1  decoded op present
- `in_ready`  out  1  op accepted when `in_valid && in_ready`
- `in_fc`  in  FC_W  ALU function code
- `in_a`, `in_b`  in  W  operands
- `in_dst`  in  DST_W  destination register
- `in_fmask`  in  3  CCR update mask {Z,N,C}
- `alu_en`  out  1  ALU enable
- `alu_fc`  out  FC_W  function code to ALU
- `alu_a`, `alu_b`  out  W  operands to ALU
- `alu_out`  in  W  ALU result
- `alu_z`, `alu_n`, `alu_c`  in  1  ALU flags
- `out_valid`  out  1  result available
- `out_ready`  in  1  EX/MEM can take result
- `out_result`  out  W  captured result
- `out_dst`  out  DST_W  destination of result
- `ccr`  out  3  {Z,N,C} condition codes
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE: `in_ready`=1. On accept with `in_fc`=NOP (0000): no ALU cycle, no output, CCR unchanged; stay in IDLE. On accept of any other code: register fc/a/b/dst/fmask and go to ISSUE.
- ISSUE: `alu_en`=1 with registered fc/a/b held stable. The ALU samples at the closing edge. Go to CAPTURE.
- CAPTURE: `alu_en`=0. At the closing edge, latch `alu_out` into `out_result`. For each bit set in `fmask`, load CCR[i] from the matching ALU flag; bits with mask 0 hold their value. Go to HOLD.
- HOLD: `out_valid`=1, with `out_result`/`out_dst` stable until the handshake.
  - If `out_ready`=1, the output transfers and `in_ready`=1 in the same cycle, allowing back-to-back accept. A non-NOP accept goes to ISSUE; otherwise go to IDLE.
  - If `out_ready`=0, hold.
- Legal codes: NOP 0000, NOT 0001 (`~b`), ADD 0010 (`a+b`, carry from bit 16). Any other code is forwarded unchanged; the result is whatever the ALU returns. The sequencer does not check code legality.
- Flush: takes priority over all events. From any state, go to IDLE at the next edge.
  - `out_valid` drops; the pending result is discarded.
  - A CCR update due at that edge is suppressed.
  - `in_ready`=0 during the flush cycle, so no op is accepted.
- Reset, asserted at any time (including mid-op):
  - State goes to IDLE; `ccr`=000; `out_result`=0; `out_dst`=0.
  - `out_valid`, `alu_en`, `busy`, `in_ready` are all 0.
  - `in_ready` rises to 1 in the first cycle after release.

## Timing
- Accept at edge k → `alu_en` high during cycle k..k+1 → capture at edge k+2 → `out_valid` high from k+2. Latency is 2 cycles.
- Throughput: one ALU op per 3 cycles with `out_ready` tied high (accept in HOLD overlaps the transfer).
- CCR changes exactly at the capture edge (k+2) and is visible in the same cycle as `out_valid`.
- `in_ready` and `out_valid` are combinational from state, `flush` and `out_ready` only; no path from `in_valid` to `in_ready`.
- ALU inputs change only on the edge that enters ISSUE.

## Structure
- Package `exec_pkg`:
  - function-code constants FC_NOP, FC_NOT, FC_ADD;
  - FSM state enum;
  - CCR bit indices CCR_Z=2, CCR_N=1, CCR_C=0.
- Sub-module `ccr_reg`: 3-bit masked-update register with async active-low reset, update enable, mask and flag inputs. It is reused later by the flag save/restore path.

## Test plan
- ADD a=0xFFFF, b=0x0001, fmask=111, `out_ready`=1 → `out_valid` 2 cycles after accept, `out_result`=0x0000, `ccr`=100 plus C → {Z=1,N=0,C=1}.
- With CCR C=1, NOT b=0x00FF, fmask=110 → `out_result`=0xFF00, Z=0, N=1, C stays 1.
- ADD 0x0003+0x0004 with `out_ready` low 3 cycles → `out_result`=0x0007 held stable, `in_ready`=0 throughout; a second op is accepted on the transfer cycle.
- NOP accepted → no `alu_en` pulse, no `out_valid`, CCR unchanged, `in_ready` high the next cycle.
- Flush asserted in CAPTURE of ADD 0x8000+0x8000 → no `out_valid`, CCR unchanged (C not set), state IDLE next cycle.
- `rst_n` dropped in HOLD → all outputs 0 immediately (asynchronous); `in_ready`=1 the first cycle after release.
